// File: rtl/mem_store_buffer.sv
// In-order store queue that drains one store per cycle into a shared memory port; loads take priority on the port.
// Build option STB_FORWARD_EN: loads forward from queued stores; otherwise a load stalls while the queue is non-empty.
module mem_store_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MATCH_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_hit,
    output logic                       ld_stall,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ADDR_W-1:0]          mem_access_addr,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic                       mem_write,
    output logic                       mem_read,
    input  logic [DATA_W-1:0]          mem_read_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              full;
    logic              push;
    logic              pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full;
    assign push     = st_valid && st_ready;

    // Entry payload needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Memory port arbitration: a load owns the port, otherwise the head store drains.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write       = 1'b0;
        mem_read        = 1'b0;
        ld_stall        = 1'b0;
        pop             = 1'b0;
`ifdef STB_FORWARD_EN
        if (ld_valid) begin
            mem_read        = 1'b1;
            mem_access_addr = ld_addr;
        end else if (!empty) begin
`else
        if (ld_valid && empty) begin
            mem_read        = 1'b1;
            mem_access_addr = ld_addr;
        end else if (!empty) begin
            ld_stall        = ld_valid;
`endif
            mem_write       = 1'b1;
            mem_access_addr = addr_q[head];
            mem_write_data  = data_q[head];
            pop             = 1'b1;
        end
    end

`ifdef STB_FORWARD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    // Oldest-to-youngest scan so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (addr_q[idx][MATCH_W-1:0] == ld_addr[MATCH_W-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_hit  = ld_valid && fwd_hit;
    assign ld_data = !ld_valid ? '0 : (fwd_hit ? fwd_data : mem_read_data);
`else
    // Match width only matters when forwarding is built in.
    logic unused_match;
    assign unused_match = 1'(MATCH_W);
    assign ld_hit       = 1'b0;
    assign ld_data      = mem_read ? mem_read_data : '0;
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mem_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [15:0] st_addr = '0;
    logic [15:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data;
    logic        ld_hit;
    logic        ld_stall;
    logic        empty;
    logic [2:0]  count;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_read_data;

    logic [15:0] mem [8];

    mem_store_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .ld_stall(ld_stall), .empty(empty), .count(count),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // 8-word memory decoded on the low three address bits.
    assign mem_read_data = mem[mem_access_addr[2:0]];
    always @(posedge clk) if (mem_write) mem[mem_access_addr[2:0]] <= mem_write_data;

`ifdef STB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct { logic [15:0] addr; logic [15:0] data; } entry_t;
    entry_t      q[$];
    logic [15:0] ref_mem [8];
    int          checks = 0;
    int          failures = 0;

    logic        e_st_ready, e_empty, e_hit, e_stall, e_write, e_read;
    logic [2:0]  e_count;
    logic [15:0] e_addr, e_wdata, e_ld_data;

    // Expected outputs for the current queue, memory and inputs.
    task automatic eval();
        e_count    = 3'(q.size());
        e_empty    = (q.size() == 0);
        e_st_ready = (q.size() < DEPTH);
        e_hit = 1'b0; e_stall = 1'b0; e_write = 1'b0; e_read = 1'b0;
        e_addr = '0; e_wdata = '0; e_ld_data = '0;
        if (ld_valid && (FWD || q.size() == 0)) begin
            e_read    = 1'b1;
            e_addr    = ld_addr;
            e_ld_data = ref_mem[ld_addr[2:0]];
            if (FWD)
                foreach (q[i])
                    if (q[i].addr[2:0] == ld_addr[2:0]) begin
                        e_hit     = 1'b1;
                        e_ld_data = q[i].data;
                    end
        end else if (q.size() > 0) begin
            e_write = 1'b1;
            e_addr  = q[0].addr;
            e_wdata = q[0].data;
            e_stall = ld_valid;
        end
    endtask

    // Advance model and DUT by one clock edge.
    task automatic tick();
        eval();
        if (e_write) begin
            ref_mem[q[0].addr[2:0]] = q[0].data;
            q.delete(0);
        end
        if (st_valid && e_st_ready) q.push_back('{addr: st_addr, data: st_data});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ld_valid = 1'b0; st_valid = 1'b0;
        #2;
        checks++; if (count !== 3'd0)       begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)       begin failures++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        checks++; if (st_ready !== 1'b1)    begin failures++; $display("FAIL rst_st_ready got=%0b exp=1", st_ready); end
        checks++; if (ld_hit !== 1'b0)      begin failures++; $display("FAIL rst_ld_hit got=%0b exp=0", ld_hit); end
        checks++; if (ld_stall !== 1'b0)    begin failures++; $display("FAIL rst_ld_stall got=%0b exp=0", ld_stall); end
        checks++; if (mem_write !== 1'b0)   begin failures++; $display("FAIL rst_mem_write got=%0b exp=0", mem_write); end
        checks++; if (mem_read !== 1'b0)    begin failures++; $display("FAIL rst_mem_read got=%0b exp=0", mem_read); end
        checks++; if (mem_access_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", mem_access_addr); end
        checks++; if (mem_write_data !== 16'h0)  begin failures++; $display("FAIL rst_wdata got=%0h exp=0", mem_write_data); end
        checks++; if (ld_data !== 16'h0)    begin failures++; $display("FAIL rst_ld_data got=%0h exp=0", ld_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_mem();
        ld_valid = 1'b1; ld_addr = 16'h1;
        #1;
        checks++; if (ld_data !== 16'h2)  begin failures++; $display("FAIL ldmem_data got=%0h exp=2", ld_data); end
        checks++; if (ld_hit !== 1'b0)    begin failures++; $display("FAIL ldmem_hit got=%0b exp=0", ld_hit); end
        checks++; if (mem_read !== 1'b1)  begin failures++; $display("FAIL ldmem_read got=%0b exp=1", mem_read); end
        checks++; if (count !== 3'd0)     begin failures++; $display("FAIL ldmem_count got=%0d exp=0", count); end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_fill_drain();
        ld_valid = 1'b1; ld_addr = 16'h7;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 16'(i); st_data = 16'hA + 16'(i);
            #1; eval();
            checks++; if (st_ready !== e_st_ready) begin failures++; $display("FAIL fill_ready i=%0d got=%0b exp=%0b", i, st_ready, e_st_ready); end
            checks++; if (count !== e_count)       begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, e_count); end
            tick();
        end
        st_valid = 1'b0;
        #1; eval();
        checks++; if (count !== e_count)       begin failures++; $display("FAIL full_count got=%0d exp=%0d", count, e_count); end
        checks++; if (st_ready !== e_st_ready) begin failures++; $display("FAIL full_ready got=%0b exp=%0b", st_ready, e_st_ready); end
`ifdef STB_FORWARD_EN
        checks++; if (count !== 3'd4 || st_ready !== 1'b0) begin failures++; $display("FAIL full_fwd count=%0d ready=%0b exp 4/0", count, st_ready); end
`endif
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; eval();
            checks++; if (mem_write !== e_write) begin failures++; $display("FAIL drain_write i=%0d got=%0b exp=%0b", i, mem_write, e_write); end
            checks++; if (mem_access_addr !== e_addr) begin failures++; $display("FAIL drain_addr i=%0d got=%0h exp=%0h", i, mem_access_addr, e_addr); end
            checks++; if (mem_write_data !== e_wdata) begin failures++; $display("FAIL drain_data i=%0d got=%0h exp=%0h", i, mem_write_data, e_wdata); end
`ifdef STB_FORWARD_EN
            checks++; if (mem_write !== 1'b1 || mem_access_addr !== 16'(i)) begin failures++; $display("FAIL drain_order i=%0d write=%0b addr=%0h exp 1/%0h", i, mem_write, mem_access_addr, i); end
`endif
            tick();
        end
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_forward();
        ld_valid = 1'b1; ld_addr = 16'h0;
        st_valid = 1'b1; st_addr = 16'h5; st_data = 16'h11; tick();
        st_data = 16'h22; tick();
        st_valid = 1'b0; ld_addr = 16'h5;
        #1; eval();
        checks++; if (ld_hit !== e_hit)      begin failures++; $display("FAIL fwd_hit got=%0b exp=%0b", ld_hit, e_hit); end
        checks++; if (ld_data !== e_ld_data) begin failures++; $display("FAIL fwd_data got=%0h exp=%0h", ld_data, e_ld_data); end
`ifdef STB_FORWARD_EN
        checks++; if (ld_hit !== 1'b1 || ld_data !== 16'h22) begin failures++; $display("FAIL fwd_young hit=%0b data=%0h exp 1/22", ld_hit, ld_data); end
`endif
        ld_addr = 16'd13;
        #1; eval();
        checks++; if (ld_data !== e_ld_data) begin failures++; $display("FAIL alias_data got=%0h exp=%0h", ld_data, e_ld_data); end
`ifdef STB_FORWARD_EN
        checks++; if (ld_data !== 16'h22) begin failures++; $display("FAIL alias_young got=%0h exp=22", ld_data); end
`endif
        tick();
        ld_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_full_concurrent();
        ld_valid = 1'b1; ld_addr = 16'h2;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 16'h8 + 16'(i); st_data = 16'h100 + 16'(i); tick();
        end
        ld_valid = 1'b0; st_valid = 1'b1; st_addr = 16'h6; st_data = 16'h66;
        #1; eval();
        checks++; if (st_ready !== e_st_ready) begin failures++; $display("FAIL cc_ready0 got=%0b exp=%0b", st_ready, e_st_ready); end
        checks++; if (mem_write !== e_write)   begin failures++; $display("FAIL cc_write0 got=%0b exp=%0b", mem_write, e_write); end
        tick();
        #1; eval();
        checks++; if (count !== e_count)       begin failures++; $display("FAIL cc_count1 got=%0d exp=%0d", count, e_count); end
        checks++; if (st_ready !== e_st_ready) begin failures++; $display("FAIL cc_ready1 got=%0b exp=%0b", st_ready, e_st_ready); end
`ifdef STB_FORWARD_EN
        checks++; if (count !== 3'd3 || st_ready !== 1'b1) begin failures++; $display("FAIL cc_fwd1 count=%0d ready=%0b exp 3/1", count, st_ready); end
`endif
        tick();
        st_valid = 1'b0;
        #1; eval();
        checks++; if (count !== e_count) begin failures++; $display("FAIL cc_count2 got=%0d exp=%0d", count, e_count); end
`ifdef STB_FORWARD_EN
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL cc_fwd2 count=%0d exp 3", count); end
`endif
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1; ld_addr = 16'h4;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 16'(i); st_data = 16'h200 + 16'(i); tick();
        end
        ld_valid = 1'b0; st_valid = 1'b0;
        tick();
        #1; eval();
        checks++; if (count !== e_count) begin failures++; $display("FAIL rm_count_pre got=%0d exp=%0d", count, e_count); end
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++; if (count !== 3'd0)     begin failures++; $display("FAIL rm_count got=%0d exp=0", count); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rm_write got=%0b exp=0", mem_write); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rm_mem idx=%0d got=%0h exp=%0h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_stall();
        ld_valid = 1'b0; st_valid = 1'b1; st_addr = 16'h3; st_data = 16'h77;
        tick();
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h3;
        #1; eval();
        checks++; if (ld_stall !== e_stall)  begin failures++; $display("FAIL st_stall0 got=%0b exp=%0b", ld_stall, e_stall); end
        checks++; if (mem_write !== e_write) begin failures++; $display("FAIL st_write0 got=%0b exp=%0b", mem_write, e_write); end
        checks++; if (ld_data !== e_ld_data) begin failures++; $display("FAIL st_data0 got=%0h exp=%0h", ld_data, e_ld_data); end
`ifndef STB_FORWARD_EN
        checks++; if (ld_stall !== 1'b1 || mem_write !== 1'b1) begin failures++; $display("FAIL st_nofwd0 stall=%0b write=%0b exp 1/1", ld_stall, mem_write); end
`endif
        tick();
        #1; eval();
        checks++; if (empty !== e_empty)     begin failures++; $display("FAIL st_empty1 got=%0b exp=%0b", empty, e_empty); end
        checks++; if (ld_stall !== e_stall)  begin failures++; $display("FAIL st_stall1 got=%0b exp=%0b", ld_stall, e_stall); end
        checks++; if (ld_data !== e_ld_data) begin failures++; $display("FAIL st_data1 got=%0h exp=%0h", ld_data, e_ld_data); end
`ifndef STB_FORWARD_EN
        checks++; if (ld_data !== 16'h77 || ld_stall !== 1'b0) begin failures++; $display("FAIL st_nofwd1 data=%0h stall=%0b exp 77/0", ld_data, ld_stall); end
`endif
        tick();
        ld_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 16'($urandom_range(0, 15));
            st_data  = 16'($urandom);
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = 16'($urandom_range(0, 15));
            #1; eval();
            checks++; if (count !== e_count)       begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, e_count); end
            checks++; if (empty !== e_empty)       begin failures++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, empty, e_empty); end
            checks++; if (st_ready !== e_st_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, st_ready, e_st_ready); end
            checks++; if (ld_hit !== e_hit)        begin failures++; $display("FAIL rnd_hit c=%0d got=%0b exp=%0b", c, ld_hit, e_hit); end
            checks++; if (ld_stall !== e_stall)    begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, ld_stall, e_stall); end
            checks++; if (ld_data !== e_ld_data)   begin failures++; $display("FAIL rnd_ld_data c=%0d got=%0h exp=%0h", c, ld_data, e_ld_data); end
            checks++; if (mem_write !== e_write)   begin failures++; $display("FAIL rnd_write c=%0d got=%0b exp=%0b", c, mem_write, e_write); end
            checks++; if (mem_read !== e_read)     begin failures++; $display("FAIL rnd_read c=%0d got=%0b exp=%0b", c, mem_read, e_read); end
            checks++; if (mem_access_addr !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, mem_access_addr, e_addr); end
            checks++; if (mem_write_data !== e_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d got=%0h exp=%0h", c, mem_write_data, e_wdata); end
            tick();
        end
        st_valid = 1'b0; ld_valid = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rnd_mem idx=%0d got=%0h exp=%0h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 16'(2 * i);
            ref_mem[i] = 16'(2 * i);
        end
        test_reset();
        test_load_mem();
        test_fill_drain();
        test_forward();
        test_full_concurrent();
        test_reset_mid();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Store buffer between the execute stage and the 16-bit data memory. Stores are queued in program order and drained one per cycle into the memory's single shared address port when no load is using it. Loads get priority on that port and read forwarded data from the youngest matching queued store, so no stale value is returned. Also owns the memory-side control signals (`mem_access_addr`, `mem_write_data`, `mem_write`, `mem_read`).

## Interface
- `DEPTH`, 4: entries; power of two, ≥2
- `ADDR_W`, 16: address width
- `DATA_W`, 16: data width
- `MATCH_W`, 3: low address bits compared for forwarding; equals the memory's decoded index width, so aliased addresses count as matches

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `st_valid`  in  1  execute stage presents a store
- `st_addr`  in  ADDR_W  store address
- `st_data`  in  DATA_W  store data
- `st_ready`  out  1  entry free; store accepted when `st_valid & st_ready`
- `ld_valid`  in  1  load request this cycle
- `ld_addr`  in  ADDR_W  load address
- `ld_data`  out  DATA_W  load result, combinational
- `ld_hit`  out  1  load was satisfied by forwarding
- `ld_stall`  out  1  load must be held and retried next cycle
- `empty`  out  1  no queued stores
- `count`  out  $clog2(DEPTH+1)  occupancy
- `mem_access_addr`  out  ADDR_W  to data memory
- `mem_write_data`  out  DATA_W  to data memory
- `mem_write`  out  1  to data memory
- `mem_read`  out  1  to data memory
- `mem_read_data`  in  DATA_W  from data memory, combinational

## Operation
- Circular FIFO with head pointer, tail pointer and count. Each entry holds {addr, data}. `full = (count==DEPTH)`.
- Push on `st_valid & st_ready`. `st_ready = !full`; it does not depend on a same-cycle pop.
- Port arbitration: `ld_valid` has priority.
  - Load cycle: `mem_read=1`, `mem_access_addr=ld_addr`, `mem_write=0`, no pop.
  - Otherwise, if `!empty`: `mem_write=1`, address and data taken from the head entry; pop at the clock edge.
  - Idle: `mem_read=0`, `mem_write=0`, `mem_access_addr=0`, `mem_write_data=0`.
- Forwarding: compare `ld_addr[MATCH_W-1:0]` with every valid entry.
  - If any entry matches, `ld_hit=1` and `ld_data` comes from the youngest match, searching from tail-1 back to head.
  - Else `ld_hit=0` and `ld_data=mem_read_data`.
  - A store pushed in the same cycle is not visible to that cycle's load.
- Simultaneous push and pop: count is unchanged and both pointers advance. With DEPTH=4 and count=4, the pop frees a slot but `st_ready` stays 0 that cycle.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.

## Timing
- Reset values: `count=0`, `empty=1`, `st_ready=1`, `ld_hit=0`, `ld_stall=0`, `mem_write=0`, `mem_read=0`.
- Under reset, `mem_access_addr=0`, `mem_write_data=0` and `ld_data=0` as long as `ld_valid=0`.
- Asserting `rst_n` low mid-operation discards all queued stores immediately; no further memory writes occur.
- All memory-side and load outputs are combinational from state and load inputs. There is no added load latency.
- Store-to-memory latency is at least 1 cycle after the push edge: the entry appears at head, then is written at the next edge if the port is free.
- Continuous `ld_valid` starves draining. The bound is the execute stage's concern; the buffer then fills and holds `st_ready=0`.

## Configuration
- `STB_FORWARD_EN` defined: forwarding behaves as above, and `ld_stall` is tied to 0.
- Not defined: no compare logic and `ld_hit` is tied to 0.
  - `ld_valid` with `!empty` gives `ld_stall=1` and `mem_read=0`, and the head drains that cycle as if there were no load.
  - `ld_valid` with `empty` is a normal memory read with `ld_stall=0`.

## Test plan
- Reset, then `ld_valid`, `ld_addr=1`, memory holding 2 at index 1 → `ld_data=2`, `ld_hit=0`, `mem_read=1`, `count=0`.
- Push stores (0,0xA),(1,0xB),(2,0xC),(3,0xD) while holding `ld_valid` → `count` reaches 4 and `st_ready=0`. Release the load → 4 consecutive `mem_write` cycles in order 0,1,2,3, then `empty=1`.
- Push (5,0x11), then (5,0x22), then load addr 5 (forwarding on) → `ld_hit=1`, `ld_data=0x22`. A load at addr 13 aliases to index 5 → `ld_data=0x22`.
- Full buffer with simultaneous pop and `st_valid` → store not accepted, `count` goes 4→3. Next cycle the store is accepted and `count` stays 3 under a concurrent drain.
- Assert `rst_n` low with `count=3` mid-drain → `count=0`, `mem_write=0` immediately, and memory keeps only the writes completed before reset.
- Without `STB_FORWARD_EN`: one store queued plus a load → `ld_stall=1`, `mem_write=1`. Next cycle `empty=1` and the retried load reads the new memory value with `ld_stall=0`.
